// File: rtl/multicycle_control_v2.sv
// multicycle_control_v2: control FSM for a multicycle CPU datapath.
// Decodes the IR opcode and sequences fetch/decode/execute/memory/writeback.
// It drives the datapath muxes, the ALU op, and the PC, IR and register-file enables.
// Memory states can wait on a mem_ready handshake guarded by a timeout.
// HALT and ERROR are terminal states that only reset_n leaves.
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   instruction         IR contents; opcode is the top WIDTH_OPCODE bits
//   zero                ALU result == 0 (branch condition)
//   mem_ready           memory access completes this cycle
//   IR_Write .. RegWrite datapath controls, decoded from state (+ zero, mem_ready)
//   halted, error       flags held for as long as the FSM sits in HALT / ERROR
//   state_dbg           current state encoding
module multicycle_control_v2 #(
  parameter int unsigned INSTRUCTION_WIDTH = 16,
  parameter int unsigned WIDTH_OPCODE      = 4,
  parameter int unsigned USE_MEM_HANDSHAKE = 1,
  parameter int unsigned MEM_TIMEOUT       = 15
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  input  logic                         zero,
  input  logic                         mem_ready,
  output logic                         IR_Write,
  output logic                         MemToReg,
  output logic                         Mem_Read_not_Write,
  output logic                         Mem_Select,
  output logic [1:0]                   PC_Source,
  output logic                         pc_write_enable,
  output logic                         alu_src_a,
  output logic [1:0]                   alu_src_b,
  output logic [2:0]                   ALUop,
  output logic                         RegWrite,
  output logic                         halted,
  output logic                         error,
  output logic [3:0]                   state_dbg
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned OPC_LO = INSTRUCTION_WIDTH - WIDTH_OPCODE;

  localparam logic [WIDTH_OPCODE-1:0] OP_NOP  = WIDTH_OPCODE'(0);
  localparam logic [WIDTH_OPCODE-1:0] OP_ADD  = WIDTH_OPCODE'(1);
  localparam logic [WIDTH_OPCODE-1:0] OP_ADDI = WIDTH_OPCODE'(2);
  localparam logic [WIDTH_OPCODE-1:0] OP_LR   = WIDTH_OPCODE'(3);
  localparam logic [WIDTH_OPCODE-1:0] OP_SR   = WIDTH_OPCODE'(4);
  localparam logic [WIDTH_OPCODE-1:0] OP_BNE  = WIDTH_OPCODE'(5);
  localparam logic [WIDTH_OPCODE-1:0] OP_LI   = WIDTH_OPCODE'(6);
  localparam logic [WIDTH_OPCODE-1:0] OP_SUB  = WIDTH_OPCODE'(7);
  localparam logic [WIDTH_OPCODE-1:0] OP_BEQ  = WIDTH_OPCODE'(8);
  localparam logic [WIDTH_OPCODE-1:0] OP_JMP  = WIDTH_OPCODE'(9);
  localparam logic [WIDTH_OPCODE-1:0] OP_AND  = WIDTH_OPCODE'(10);
  localparam logic [WIDTH_OPCODE-1:0] OP_OR   = WIDTH_OPCODE'(11);
  localparam logic [WIDTH_OPCODE-1:0] OP_HALT = WIDTH_OPCODE'(15);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_IF        = 4'd1,
    S_ID        = 4'd2,
    S_R_EXE     = 4'd3,
    S_LR_ADDR   = 4'd4,
    S_SR_ADDR   = 4'd5,
    S_BRANCH    = 4'd6,
    S_JUMP      = 4'd7,
    S_HALT      = 4'd8,
    S_MEM_READ  = 4'd9,
    S_MEM_WB    = 4'd10,
    S_MEM_STORE = 4'd11,
    S_ALU_WB    = 4'd12,
    S_ERROR     = 4'd13
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic [WIDTH_OPCODE-1:0] opcode;
  logic                    mem_rdy;
  logic                    mem_wait;
  logic                    take_branch;
  logic                    unused_instr_bits;

  assign opcode            = instruction[INSTRUCTION_WIDTH-1 -: WIDTH_OPCODE];
  assign unused_instr_bits = ^instruction[OPC_LO-1:0];
  assign state_dbg         = state_q;

  // Without the handshake every memory access is assumed to finish in one cycle.
  assign mem_rdy = (USE_MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  // States that stall on memory and therefore run the timeout counter.
  assign mem_wait = ((state_q == S_IF) || (state_q == S_MEM_READ) ||
                     (state_q == S_MEM_STORE)) && !mem_rdy;

  assign take_branch = (opcode == OP_BNE) ? !zero : zero;

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_RESET;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d            = state_q;
    wait_cnt_d         = '0;
    IR_Write           = 1'b0;
    MemToReg           = 1'b0;
    Mem_Read_not_Write = 1'b1;
    Mem_Select         = 1'b0;
    PC_Source          = 2'd0;
    pc_write_enable    = 1'b0;
    alu_src_a          = 1'b0;
    alu_src_b          = 2'd0;
    ALUop              = ALU_ADD;
    RegWrite           = 1'b0;
    halted             = 1'b0;
    error              = 1'b0;

    case (state_q)
      S_RESET: begin
        PC_Source       = 2'd3;
        pc_write_enable = 1'b1;
        state_d         = S_IF;
      end
      S_IF: begin
        alu_src_b       = 2'd1;
        IR_Write        = mem_rdy;
        pc_write_enable = mem_rdy;
        if (mem_rdy) state_d = S_ID;
      end
      S_ID: begin
        // PC + immediate is latched in the ALU buffer as the branch target.
        alu_src_b = 2'd2;
        case (opcode)
          OP_NOP:                                       state_d = S_IF;
          OP_ADD, OP_ADDI, OP_LI, OP_SUB, OP_AND, OP_OR: state_d = S_R_EXE;
          OP_LR:                                        state_d = S_LR_ADDR;
          OP_SR:                                        state_d = S_SR_ADDR;
          OP_BNE, OP_BEQ:                               state_d = S_BRANCH;
          OP_JMP:                                       state_d = S_JUMP;
          OP_HALT:                                      state_d = S_HALT;
          default:                                      state_d = S_ERROR;
        endcase
      end
      S_R_EXE: begin
        alu_src_a = 1'b1;
        alu_src_b = ((opcode == OP_ADDI) || (opcode == OP_LI)) ? 2'd2 : 2'd0;
        case (opcode)
          OP_SUB:  ALUop = ALU_SUB;
          OP_AND:  ALUop = ALU_AND;
          OP_OR:   ALUop = ALU_OR;
          default: ALUop = ALU_ADD;
        endcase
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        state_d  = S_IF;
      end
      S_LR_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = S_MEM_READ;
      end
      S_SR_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = S_MEM_STORE;
      end
      S_MEM_READ: begin
        Mem_Select = 1'b1;
        if (mem_rdy) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        Mem_Select = 1'b1;
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        state_d    = S_IF;
      end
      S_MEM_STORE: begin
        Mem_Select         = 1'b1;
        Mem_Read_not_Write = 1'b0;
        if (mem_rdy) state_d = S_IF;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd0;
        ALUop     = ALU_SUB;
        if (take_branch) begin
          pc_write_enable = 1'b1;
          PC_Source       = 2'd1;
        end
        state_d = S_IF;
      end
      S_JUMP: begin
        PC_Source       = 2'd2;
        pc_write_enable = 1'b1;
        state_d         = S_IF;
      end
      S_HALT:  halted = 1'b1;
      S_ERROR: error  = 1'b1;
      default: state_d = S_ERROR;
    endcase

    // Stalled memory access: count, or give up once the budget is spent.
    if (mem_wait) begin
      if (wait_cnt_q == TIMEOUT_CNT) state_d = S_ERROR;
      else                           wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control_v2.sv
// Testbench for multicycle_control_v2 (MEM_TIMEOUT=4, handshake enabled).
// Each step drives opcode/zero/mem_ready and pushes the expected control word.
// The expected word is popped and compared against the DUT on the following negedge.
module tb_multicycle_control_v2;

  localparam logic [3:0] S_RESET = 4'd0,  S_IF = 4'd1,  S_ID = 4'd2,  S_R_EXE = 4'd3;
  localparam logic [3:0] S_LR_ADDR = 4'd4, S_SR_ADDR = 4'd5, S_BRANCH = 4'd6, S_JUMP = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8, S_MEM_READ = 4'd9, S_MEM_WB = 4'd10;
  localparam logic [3:0] S_MEM_STORE = 4'd11, S_ALU_WB = 4'd12, S_ERROR = 4'd13;

  typedef struct packed {
    logic [3:0] st;
    logic       ir_write;
    logic       mem_to_reg;
    logic       rnw;
    logic       msel;
    logic [1:0] pcs;
    logic       pcwe;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] aluop;
    logic       reg_write;
    logic       halted;
    logic       error;
  } obs_t;

  typedef struct packed {
    logic [3:0] op;
    logic       z;
    logic       r;
    logic [3:0] st;
  } step_t;

  logic        clk;
  logic        reset_n;
  logic [15:0] instruction;
  logic        zero;
  logic        mem_ready;
  logic        IR_Write, MemToReg, Mem_Read_not_Write, Mem_Select;
  logic [1:0]  PC_Source;
  logic        pc_write_enable, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  ALUop;
  logic        RegWrite, halted, error;
  logic [3:0]  state_dbg;

  obs_t sb[$];
  obs_t exp_o, act_o;
  int   n_cmp  = 0;
  int   n_fail = 0;

  multicycle_control_v2 #(
    .INSTRUCTION_WIDTH(16),
    .WIDTH_OPCODE(4),
    .USE_MEM_HANDSHAKE(1),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .zero(zero),
    .mem_ready(mem_ready), .IR_Write(IR_Write), .MemToReg(MemToReg),
    .Mem_Read_not_Write(Mem_Read_not_Write), .Mem_Select(Mem_Select),
    .PC_Source(PC_Source), .pc_write_enable(pc_write_enable),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUop(ALUop),
    .RegWrite(RegWrite), .halted(halted), .error(error), .state_dbg(state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference control word for a given state and inputs, from the behaviour table.
  function automatic obs_t exp_out(input logic [3:0] st, input logic [3:0] op,
                                   input logic z, input logic r);
    obs_t o;
    o     = '0;
    o.st  = st;
    o.rnw = 1'b1;
    if (st == S_RESET) begin o.pcs = 2'd3; o.pcwe = 1'b1; end
    if (st == S_IF)    begin o.asb = 2'd1; o.ir_write = r; o.pcwe = r; end
    if (st == S_ID)    o.asb = 2'd2;
    if (st == S_R_EXE) begin
      o.asa   = 1'b1;
      o.asb   = (op == 4'd2 || op == 4'd6) ? 2'd2 : 2'd0;
      o.aluop = (op == 4'd7) ? 3'd1 : (op == 4'd10) ? 3'd2 : (op == 4'd11) ? 3'd3 : 3'd0;
    end
    if (st == S_ALU_WB) o.reg_write = 1'b1;
    if (st == S_LR_ADDR || st == S_SR_ADDR) begin o.asa = 1'b1; o.asb = 2'd2; end
    if (st == S_MEM_READ) o.msel = 1'b1;
    if (st == S_MEM_WB) begin o.msel = 1'b1; o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
    if (st == S_MEM_STORE) begin o.msel = 1'b1; o.rnw = 1'b0; end
    if (st == S_BRANCH) begin
      o.asa   = 1'b1;
      o.aluop = 3'd1;
      if ((op == 4'd5 && !z) || (op == 4'd8 && z)) begin o.pcwe = 1'b1; o.pcs = 2'd1; end
    end
    if (st == S_JUMP)  begin o.pcs = 2'd2; o.pcwe = 1'b1; end
    if (st == S_HALT)  o.halted = 1'b1;
    if (st == S_ERROR) o.error = 1'b1;
    return o;
  endfunction

  function automatic obs_t get_obs();
    obs_t o;
    o = '{st: state_dbg, ir_write: IR_Write, mem_to_reg: MemToReg, rnw: Mem_Read_not_Write,
          msel: Mem_Select, pcs: PC_Source, pcwe: pc_write_enable, asa: alu_src_a,
          asb: alu_src_b, aluop: ALUop, reg_write: RegWrite, halted: halted, error: error};
    return o;
  endfunction

  function automatic step_t mk(input logic [3:0] op, input logic z, input logic r,
                               input logic [3:0] st);
    step_t s;
    s.op = op; s.z = z; s.r = r; s.st = st;
    return s;
  endfunction

  // Drive one cycle of inputs just after the edge and queue the expected control word.
  task automatic drive_step(input step_t s);
    @(posedge clk);
    #1;
    instruction = {s.op, 12'($urandom)};
    zero        = s.z;
    mem_ready   = s.r;
    sb.push_back(exp_out(s.st, s.op, s.z, s.r));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; instruction = '0; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin @(posedge clk); #1 reset_n = 1'b1; end
      else        @(posedge clk);
      sb.push_back(exp_out(S_RESET, 4'd0, 1'b0, 1'b1));
      @(negedge clk);
      exp_o = sb.pop_front(); act_o = get_obs(); n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h expected %h", i, act_o, exp_o);
      end
    end
  endtask

  task automatic test_nop();
    step_t seq[$];
    for (int k = 0; k < 2; k++) begin
      seq.push_back(mk(4'd0, 1'b0, 1'b1, S_IF));
      seq.push_back(mk(4'd0, 1'b0, 1'b1, S_ID));
    end
    foreach (seq[i]) begin
      drive_step(seq[i]);
      @(negedge clk);
      exp_o = sb.pop_front(); act_o = get_obs(); n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL nop[%0d]: got %h expected %h", i, act_o, exp_o);
      end
    end
  endtask

  task automatic test_alu();
    step_t seq[$];
    logic [3:0] ops [6];
    ops = '{4'd1, 4'd7, 4'd10, 4'd11, 4'd2, 4'd6};
    foreach (ops[k]) begin
      seq.push_back(mk(ops[k], 1'b0, 1'b1, S_IF));
      seq.push_back(mk(ops[k], 1'b0, 1'b1, S_ID));
      seq.push_back(mk(ops[k], 1'b0, 1'b1, S_R_EXE));
      seq.push_back(mk(ops[k], 1'b0, 1'b1, S_ALU_WB));
    end
    foreach (seq[i]) begin
      drive_step(seq[i]);
      @(negedge clk);
      exp_o = sb.pop_front(); act_o = get_obs(); n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL alu[%0d] op=%0d: got %h expected %h", i, seq[i].op, act_o, exp_o);
      end
    end
  endtask

  task automatic test_load();
    step_t seq[$];
    seq.push_back(mk(4'd3, 1'b0, 1'b0, S_IF));
    seq.push_back(mk(4'd3, 1'b0, 1'b0, S_IF));
    seq.push_back(mk(4'd3, 1'b0, 1'b1, S_IF));
    seq.push_back(mk(4'd3, 1'b0, 1'b1, S_ID));
    seq.push_back(mk(4'd3, 1'b0, 1'b0, S_LR_ADDR));
    for (int k = 0; k < 3; k++) seq.push_back(mk(4'd3, 1'b0, 1'b0, S_MEM_READ));
    seq.push_back(mk(4'd3, 1'b0, 1'b1, S_MEM_READ));
    seq.push_back(mk(4'd3, 1'b0, 1'b0, S_MEM_WB));
    foreach (seq[i]) begin
      drive_step(seq[i]);
      @(negedge clk);
      exp_o = sb.pop_front(); act_o = get_obs(); n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL load[%0d]: got %h expected %h", i, act_o, exp_o);
      end
    end
  endtask

  task automatic test_branch_jump();
    step_t seq[$];
    logic [3:0] ops [5];
    logic       zs  [5];
    ops = '{4'd5, 4'd5, 4'd8, 4'd8, 4'd9};
    zs  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    foreach (ops[k]) begin
      seq.push_back(mk(ops[k], zs[k], 1'b1, S_IF));
      seq.push_back(mk(ops[k], zs[k], 1'b1, S_ID));
      seq.push_back(mk(ops[k], zs[k], 1'b1, (ops[k] == 4'd9) ? S_JUMP : S_BRANCH));
    end
    foreach (seq[i]) begin
      drive_step(seq[i]);
      @(negedge clk);
      exp_o = sb.pop_front(); act_o = get_obs(); n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL branch[%0d] op=%0d z=%0b: got %h expected %h",
                 i, seq[i].op, seq[i].z, act_o, exp_o);
      end
    end
  endtask

  // Store completing on the last allowed wait cycle: mem_ready beats the timeout.
  task automatic test_store();
    step_t seq[$];
    seq.push_back(mk(4'd4, 1'b0, 1'b1, S_IF));
    seq.push_back(mk(4'd4, 1'b0, 1'b1, S_ID));
    seq.push_back(mk(4'd4, 1'b0, 1'b0, S_SR_ADDR));
    for (int k = 0; k < 4; k++) seq.push_back(mk(4'd4, 1'b0, 1'b0, S_MEM_STORE));
    seq.push_back(mk(4'd4, 1'b0, 1'b1, S_MEM_STORE));
    seq.push_back(mk(4'd0, 1'b0, 1'b1, S_IF));
    seq.push_back(mk(4'd0, 1'b0, 1'b1, S_ID));
    foreach (seq[i]) begin
      drive_step(seq[i]);
      @(negedge clk);
      exp_o = sb.pop_front(); act_o = get_obs(); n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL store[%0d]: got %h expected %h", i, act_o, exp_o);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    step_t seq[$];
    seq.push_back(mk(4'd4, 1'b0, 1'b1, S_IF));
    seq.push_back(mk(4'd4, 1'b0, 1'b1, S_ID));
    seq.push_back(mk(4'd4, 1'b0, 1'b0, S_SR_ADDR));
    seq.push_back(mk(4'd4, 1'b0, 1'b0, S_MEM_STORE));
    foreach (seq[i]) begin
      drive_step(seq[i]);
      @(negedge clk);
      exp_o = sb.pop_front(); act_o = get_obs(); n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL mid_store[%0d]: got %h expected %h", i, act_o, exp_o);
      end
    end
    // Reset lands between edges: write strobe must drop without waiting for a clock.
    #1 reset_n = 1'b0;
    sb.push_back(exp_out(S_RESET, 4'd4, 1'b0, 1'b0));
    #1;
    exp_o = sb.pop_front(); act_o = get_obs(); n_cmp++;
    if (act_o !== exp_o) begin
      n_fail++;
      $display("FAIL mid_store_async: got %h expected %h", act_o, exp_o);
    end
    #1 reset_n = 1'b1;
    seq.delete();
    seq.push_back(mk(4'd0, 1'b0, 1'b1, S_IF));
    seq.push_back(mk(4'd0, 1'b0, 1'b1, S_ID));
    foreach (seq[i]) begin
      drive_step(seq[i]);
      @(negedge clk);
      exp_o = sb.pop_front(); act_o = get_obs(); n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL mid_store_recover[%0d]: got %h expected %h", i, act_o, exp_o);
      end
    end
  endtask

  task automatic test_timeout();
    step_t seq[$];
    seq.push_back(mk(4'd4, 1'b0, 1'b1, S_IF));
    seq.push_back(mk(4'd4, 1'b0, 1'b1, S_ID));
    seq.push_back(mk(4'd4, 1'b0, 1'b0, S_SR_ADDR));
    for (int k = 0; k < 5; k++) seq.push_back(mk(4'd4, 1'b0, 1'b0, S_MEM_STORE));
    for (int k = 0; k < 3; k++) seq.push_back(mk(4'd0, 1'b0, 1'b1, S_ERROR));
    foreach (seq[i]) begin
      drive_step(seq[i]);
      @(negedge clk);
      exp_o = sb.pop_front(); act_o = get_obs(); n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL store_timeout[%0d]: got %h expected %h", i, act_o, exp_o);
      end
    end
    do_reset();
    seq.delete();
    for (int k = 0; k < 5; k++) seq.push_back(mk(4'd0, 1'b0, 1'b0, S_IF));
    seq.push_back(mk(4'd0, 1'b0, 1'b1, S_ERROR));
    foreach (seq[i]) begin
      drive_step(seq[i]);
      @(negedge clk);
      exp_o = sb.pop_front(); act_o = get_obs(); n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL fetch_timeout[%0d]: got %h expected %h", i, act_o, exp_o);
      end
    end
    do_reset();
  endtask

  task automatic test_illegal();
    step_t seq[$];
    seq.push_back(mk(4'd12, 1'b0, 1'b1, S_IF));
    seq.push_back(mk(4'd12, 1'b0, 1'b1, S_ID));
    seq.push_back(mk(4'd0,  1'b0, 1'b1, S_ERROR));
    seq.push_back(mk(4'd1,  1'b0, 1'b1, S_ERROR));
    foreach (seq[i]) begin
      drive_step(seq[i]);
      @(negedge clk);
      exp_o = sb.pop_front(); act_o = get_obs(); n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL illegal[%0d]: got %h expected %h", i, act_o, exp_o);
      end
    end
    do_reset();
  endtask

  task automatic test_halt();
    step_t seq[$];
    seq.push_back(mk(4'd15, 1'b0, 1'b1, S_IF));
    seq.push_back(mk(4'd15, 1'b0, 1'b1, S_ID));
    seq.push_back(mk(4'd15, 1'b0, 1'b1, S_HALT));
    seq.push_back(mk(4'd0,  1'b1, 1'b0, S_HALT));
    seq.push_back(mk(4'd1,  1'b0, 1'b1, S_HALT));
    foreach (seq[i]) begin
      drive_step(seq[i]);
      @(negedge clk);
      exp_o = sb.pop_front(); act_o = get_obs(); n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL halt[%0d]: got %h expected %h", i, act_o, exp_o);
      end
    end
    do_reset();
    sb.push_back(exp_out(S_RESET, 4'd1, 1'b0, 1'b1));
    @(negedge clk);
    exp_o = sb.pop_front(); act_o = get_obs(); n_cmp++;
    if (act_o !== exp_o) begin
      n_fail++;
      $display("FAIL halt_cleared: got %h expected %h", act_o, exp_o);
    end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_alu();
    test_load();
    test_branch_jump();
    test_store();
    test_reset_mid_store();
    test_timeout();
    test_illegal();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
